// File: rtl/dp_pkg.sv
// Shared definitions for the datapath arbiter: command bundle layout, arbiter
// state encoding and the ALU opcodes shared with the control unit.
package dp_pkg;

  localparam int unsigned CMD_W       = 28;
  localparam int unsigned RDATA_W     = 16;

  // Command bundle field layout, LSB first.
  localparam int unsigned ALU_S_LSB   = 0;
  localparam int unsigned ALU_S_W     = 3;
  localparam int unsigned RB_RD_BIT   = 3;
  localparam int unsigned RB_ADDR_LSB = 4;
  localparam int unsigned RA_RD_BIT   = 8;
  localparam int unsigned RA_ADDR_LSB = 9;
  localparam int unsigned W_WR_BIT    = 13;
  localparam int unsigned W_ADDR_LSB  = 14;
  localparam int unsigned RF_ADDR_W   = 4;
  localparam int unsigned RF_S_BIT    = 18;
  localparam int unsigned D_WR_BIT    = 19;
  localparam int unsigned D_ADDR_LSB  = 20;
  localparam int unsigned D_ADDR_W    = 8;

  localparam logic [ALU_S_W-1:0] ALU_PASS_A = 3'd0;
  localparam logic [ALU_S_W-1:0] ALU_ADD    = 3'd1;
  localparam logic [ALU_S_W-1:0] ALU_SUB    = 3'd2;
  localparam logic [ALU_S_W-1:0] ALU_AND    = 3'd3;
  localparam logic [ALU_S_W-1:0] ALU_OR     = 3'd4;
  localparam logic [ALU_S_W-1:0] ALU_XOR    = 3'd5;
  localparam logic [ALU_S_W-1:0] ALU_NOT_A  = 3'd6;
  localparam logic [ALU_S_W-1:0] ALU_PASS_B = 3'd7;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StOwnCpu  = 2'd1,
    StOwnHost = 2'd2
  } arb_state_e;

  typedef enum logic {
    OwnerCpu  = 1'b0,
    OwnerHost = 1'b1
  } owner_e;

  function automatic logic [D_ADDR_W-1:0] cmd_d_addr(input logic [CMD_W-1:0] cmd);
    return cmd[D_ADDR_LSB +: D_ADDR_W];
  endfunction

endpackage

// File: rtl/dp_arbiter_if.sv
// Requester/datapath bundle around the arbiter. master = CPU/HOST/datapath side,
// slave = the arbiter itself.
interface dp_arbiter_if #(
  parameter int unsigned CMD_W = 28
) ();

  logic             cpu_req;
  logic             cpu_last;
  logic [CMD_W-1:0] cpu_cmd;
  logic             cpu_gnt;
  logic             host_req;
  logic             host_last;
  logic [CMD_W-1:0] host_cmd;
  logic             host_gnt;
  logic [15:0]      dp_mux_out;
  logic [CMD_W-1:0] dp_cmd;
  logic [15:0]      host_rdata;
  logic             host_rvalid;

  modport master (
    output cpu_req, cpu_last, cpu_cmd,
    output host_req, host_last, host_cmd,
    output dp_mux_out,
    input  cpu_gnt, host_gnt, dp_cmd, host_rdata, host_rvalid
  );

  modport slave (
    input  cpu_req, cpu_last, cpu_cmd,
    input  host_req, host_last, host_cmd,
    input  dp_mux_out,
    output cpu_gnt, host_gnt, dp_cmd, host_rdata, host_rvalid
  );

endinterface

// File: rtl/dp_arb_sel.sv
// Combinational winner selection between CPU and HOST. rr_ptr names the requester
// served last; on a tie the other one wins unless HOST priority is configured.
module dp_arb_sel
  import dp_pkg::*;
#(
  parameter int unsigned HOST_PRIO = 0
) (
  input  logic   cpu_req,
  input  logic   host_req,
  input  owner_e rr_ptr,
  output logic   pick_cpu,
  output logic   pick_host
);

  always_comb begin
    pick_cpu  = 1'b0;
    pick_host = 1'b0;
    if (cpu_req && host_req) begin
      if ((HOST_PRIO != 0) || (rr_ptr == OwnerCpu)) begin
        pick_host = 1'b1;
      end else begin
        pick_cpu = 1'b1;
      end
    end else begin
      pick_cpu  = cpu_req;
      pick_host = host_req;
    end
  end

endmodule

// File: rtl/dp_arbiter.sv
// Registered-grant arbiter sharing the datapath command bundle between the CPU
// control unit and the host loader, with beat timeout and host read capture.
module dp_arbiter
  import dp_pkg::*;
#(
  parameter int unsigned CMD_W     = dp_pkg::CMD_W,
  parameter int unsigned HOST_PRIO = 0,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  dp_arbiter_if.slave bus,
  output logic        err_timeout,
  output logic [1:0]  arb_state
);

  localparam int unsigned CntW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(MAX_BEATS - 1);

  arb_state_e       state_q, state_d;
  owner_e           rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]  beat_cnt_q, beat_cnt_d;
  logic             err_q, err_d;
  logic [15:0]      rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic [CMD_W-1:0] dp_cmd;

  logic   owned, owner_host, owner_req, owner_last, beat, timeout, release_own;
  owner_e sel_ptr;
  logic   pick_cpu, pick_host;

  assign owned       = (state_q != StIdle);
  assign owner_host  = (state_q == StOwnHost);
  assign owner_req   = owner_host ? bus.host_req  : bus.cpu_req;
  assign owner_last  = owner_host ? bus.host_last : bus.cpu_last;
  assign beat        = owned && owner_req;
  assign timeout     = beat && !owner_last && (beat_cnt_q == LastBeat);
  assign release_own = owned && (!owner_req || owner_last || timeout);

  // On release the pointer is the releasing owner, so a waiting other requester
  // takes over without a bubble; otherwise the same one may keep the grant.
  assign sel_ptr = owned ? (owner_host ? OwnerHost : OwnerCpu) : rr_ptr_q;

  dp_arb_sel #(
    .HOST_PRIO(HOST_PRIO)
  ) u_sel (
    .cpu_req  (bus.cpu_req),
    .host_req (bus.host_req),
    .rr_ptr   (sel_ptr),
    .pick_cpu (pick_cpu),
    .pick_host(pick_host)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q || timeout;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    dp_cmd     = '0;

    unique case (state_q)
      StIdle: begin
        beat_cnt_d = '0;
        if (pick_cpu) begin
          state_d = StOwnCpu;
        end else if (pick_host) begin
          state_d = StOwnHost;
        end
      end
      StOwnCpu, StOwnHost: begin
        if (beat) begin
          dp_cmd = owner_host ? bus.host_cmd : bus.cpu_cmd;
        end
        if (release_own) begin
          rr_ptr_d   = owner_host ? OwnerHost : OwnerCpu;
          beat_cnt_d = '0;
          if (pick_cpu) begin
            state_d = StOwnCpu;
          end else if (pick_host) begin
            state_d = StOwnHost;
          end else begin
            state_d = StIdle;
          end
          // Only a normal last beat returns read data; forced/abandoned do not.
          if (owner_host && beat && owner_last) begin
            rdata_d  = bus.dp_mux_out;
            rvalid_d = 1'b1;
          end
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= StIdle;
      rr_ptr_q   <= OwnerHost;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign bus.cpu_gnt     = (state_q == StOwnCpu);
  assign bus.host_gnt    = (state_q == StOwnHost);
  assign bus.dp_cmd      = dp_cmd;
  assign bus.host_rdata  = rdata_q;
  assign bus.host_rvalid = rvalid_q;
  assign err_timeout     = err_q;
  assign arb_state       = state_q;

endmodule

// File: tb/tb_dp_arbiter.sv
// Random-stimulus scoreboard bench: a round-robin and a host-priority arbiter
// share the same inputs and are checked against an owner-level reference model.
module tb_dp_arbiter;
  import dp_pkg::*;

  localparam int unsigned MB   = 4;
  localparam int unsigned NCYC = 900;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  logic             cpu_req, cpu_last, host_req, host_last;
  logic [CMD_W-1:0] cpu_cmd, host_cmd;
  logic [15:0]      dp_mux_out;

  dp_arbiter_if #(.CMD_W(CMD_W)) bus0 ();
  dp_arbiter_if #(.CMD_W(CMD_W)) bus1 ();

  assign bus0.cpu_req = cpu_req;     assign bus1.cpu_req = cpu_req;
  assign bus0.cpu_last = cpu_last;   assign bus1.cpu_last = cpu_last;
  assign bus0.cpu_cmd = cpu_cmd;     assign bus1.cpu_cmd = cpu_cmd;
  assign bus0.host_req = host_req;   assign bus1.host_req = host_req;
  assign bus0.host_last = host_last; assign bus1.host_last = host_last;
  assign bus0.host_cmd = host_cmd;   assign bus1.host_cmd = host_cmd;
  assign bus0.dp_mux_out = dp_mux_out;
  assign bus1.dp_mux_out = dp_mux_out;

  logic       err0, err1;
  logic [1:0] st0, st1;

  dp_arbiter #(.CMD_W(CMD_W), .HOST_PRIO(0), .MAX_BEATS(MB)) u_rr (
    .Clk(Clk), .Reset(Reset), .bus(bus0), .err_timeout(err0), .arb_state(st0)
  );
  dp_arbiter #(.CMD_W(CMD_W), .HOST_PRIO(1), .MAX_BEATS(MB)) u_hp (
    .Clk(Clk), .Reset(Reset), .bus(bus1), .err_timeout(err1), .arb_state(st1)
  );

  typedef struct packed {
    logic [1:0]       st;
    logic [CMD_W-1:0] cmd;
    logic             rvalid;
    logic [15:0]      rdata;
    logic             err;
  } exp_t;

  exp_t        exp_q0[$], exp_q1[$];
  logic [15:0] rd_q0[$], rd_q1[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference model: owner 0 = nobody, 1 = CPU, 2 = HOST.
  int          m_owner[2];
  int          m_beats[2];
  int          m_served[2];
  bit          m_err[2];
  bit          m_rvalid[2];
  logic [15:0] m_rdata[2];
  bit          prio[2];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got %h required %h", name, $time, act, req);
    end
  endtask

  function automatic bit req_of(input int who);
    return (who == 1) ? cpu_req : host_req;
  endfunction

  function automatic bit last_of(input int who);
    return (who == 1) ? cpu_last : host_last;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_owner[i] = 0; m_beats[i] = 0; m_served[i] = 2;
      m_err[i] = 0; m_rvalid[i] = 0; m_rdata[i] = '0;
    end
    rd_q0.delete();
    rd_q1.delete();
  endtask

  function automatic exp_t model_out(input int i);
    exp_t e;
    e.st     = 2'(m_owner[i]);
    e.cmd    = '0;
    if (m_owner[i] == 1 && cpu_req) e.cmd = cpu_cmd;
    if (m_owner[i] == 2 && host_req) e.cmd = host_cmd;
    e.rvalid = m_rvalid[i];
    e.rdata  = m_rdata[i];
    e.err    = m_err[i];
    return e;
  endfunction

  // Who gets the datapath next: HOST if it has priority and asks; otherwise a
  // requester that was not just served; otherwise whoever is asking.
  function automatic int choose(input int i, input int just_served);
    int other;
    other = 3 - just_served;
    if (prio[i] && host_req) return 2;
    if (req_of(other)) return other;
    if (req_of(just_served)) return just_served;
    return 0;
  endfunction

  task automatic model_step(input int i);
    int o;
    bit rel, cap;
    o   = m_owner[i];
    rel = 0;
    cap = 0;
    if (o == 0) begin
      m_owner[i] = choose(i, m_served[i]);
      m_beats[i] = 0;
    end else begin
      if (!req_of(o)) begin
        rel = 1;
      end else begin
        m_beats[i]++;
        if (last_of(o)) begin
          rel = 1;
          cap = (o == 2);
        end else if (m_beats[i] == MB) begin
          rel = 1;
          m_err[i] = 1;
        end
      end
      if (rel) begin
        m_served[i] = o;
        m_owner[i]  = choose(i, o);
        m_beats[i]  = 0;
      end
    end
    m_rvalid[i] = cap;
    if (cap) begin
      m_rdata[i] = dp_mux_out;
      if (i == 0) rd_q0.push_back(dp_mux_out);
      else rd_q1.push_back(dp_mux_out);
    end
  endtask

  task automatic check_cycle(input string tag, input exp_t e, input logic [1:0] st,
                             input logic cg, input logic hg, input logic [CMD_W-1:0] cmd,
                             input logic rv, input logic [15:0] rd, input logic er);
    cmp({tag, "_arb_state"}, 32'(st), 32'(e.st));
    cmp({tag, "_cpu_gnt"}, 32'(cg), 32'(e.st == 2'd1));
    cmp({tag, "_host_gnt"}, 32'(hg), 32'(e.st == 2'd2));
    cmp({tag, "_dp_cmd"}, 32'(cmd), 32'(e.cmd));
    cmp({tag, "_host_rvalid"}, 32'(rv), 32'(e.rvalid));
    cmp({tag, "_host_rdata"}, 32'(rd), 32'(e.rdata));
    cmp({tag, "_err_timeout"}, 32'(er), 32'(e.err));
  endtask

  // Monitor: every cycle's outputs against the queued expectation, and every
  // read-return pulse against the queued captured value.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        check_cycle("rr", e, st0, bus0.cpu_gnt, bus0.host_gnt, bus0.dp_cmd,
                    bus0.host_rvalid, bus0.host_rdata, err0);
      end
      if (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        check_cycle("hp", e, st1, bus1.cpu_gnt, bus1.host_gnt, bus1.dp_cmd,
                    bus1.host_rvalid, bus1.host_rdata, err1);
      end
      if (bus0.host_rvalid === 1'b1) begin
        if (rd_q0.size() == 0) cmp("rr_unexpected_rvalid", 32'd1, 32'd0);
        else cmp("rr_read_return", 32'(bus0.host_rdata), 32'(rd_q0.pop_front()));
      end
      if (bus1.host_rvalid === 1'b1) begin
        if (rd_q1.size() == 0) cmp("hp_unexpected_rvalid", 32'd1, 32'd0);
        else cmp("hp_read_return", 32'(bus1.host_rdata), 32'(rd_q1.pop_front()));
      end
    end
  end

  task automatic gen_inputs(input int c, input bit force_both);
    cpu_cmd    = CMD_W'($urandom);
    host_cmd   = CMD_W'($urandom);
    dp_mux_out = 16'($urandom);
    if (c < 60) begin
      cpu_req = 1; host_req = 1; cpu_last = 1; host_last = 1;
    end else if (c < 120) begin
      cpu_req = 1; cpu_last = 0;
      host_req = ((c % 20) >= 15); host_last = 1;
    end else if (c < 170) begin
      cpu_req = 1; host_req = 1;
      cpu_last = ($urandom_range(0, 1) == 0); host_last = ($urandom_range(0, 1) == 0);
    end else begin
      cpu_req   = ($urandom_range(0, 3) != 0);
      host_req  = ($urandom_range(0, 3) != 0);
      cpu_last  = ($urandom_range(0, 2) == 0);
      host_last = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) begin
        host_cmd[D_ADDR_LSB +: D_ADDR_W] = 8'h2A;
        dp_mux_out = 16'hBEEF;
      end
    end
    if (force_both) begin
      cpu_req = 1; host_req = 1;
    end
  endtask

  initial begin
    bit in_reset, mid_done, force_both;
    prio[0] = 0;
    prio[1] = 1;
    Reset = 0;
    cpu_req = 0; cpu_last = 0; host_req = 0; host_last = 0;
    cpu_cmd = '0; host_cmd = '0; dp_mux_out = '0;
    model_reset();
    in_reset   = 1;
    mid_done   = 0;
    force_both = 0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge Clk);
      #1;
      force_both = 0;
      if (in_reset) begin
        Reset = 1;
        in_reset = 0;
        force_both = 1;
      end else if (c >= 300 && !mid_done && m_owner[0] == 2) begin
        // Asynchronous reset while HOST owns: outputs must clear at once.
        Reset = 0;
        in_reset = 1;
        mid_done = 1;
        #1;
        cmp("reset_rr_state", 32'(st0), 32'd0);
        cmp("reset_rr_host_gnt", 32'(bus0.host_gnt), 32'd0);
        cmp("reset_rr_cpu_gnt", 32'(bus0.cpu_gnt), 32'd0);
        cmp("reset_rr_dp_cmd", 32'(bus0.dp_cmd), 32'd0);
        cmp("reset_rr_err", 32'(err0), 32'd0);
        cmp("reset_hp_state", 32'(st1), 32'd0);
        cmp("reset_hp_dp_cmd", 32'(bus1.dp_cmd), 32'd0);
        cmp("reset_hp_rvalid", 32'(bus1.host_rvalid), 32'd0);
      end
      gen_inputs(c, force_both);
      if (in_reset) model_reset();
      exp_q0.push_back(model_out(0));
      exp_q1.push_back(model_out(1));
      if (!in_reset) begin
        model_step(0);
        model_step(1);
      end
    end
    repeat (2) @(posedge Clk);
    if (!mid_done) cmp("mid_grant_reset_reached", 32'd0, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dp_arbiter.md
Name: dp_arbiter

Overview:
Shares the single Datapath control bundle between two requesters: the instruction control unit (CPU) and a host/debug loader (HOST).
- HOST preloads and inspects data memory and the register file.
- Grants are registered and held for multi-beat transactions.
- Ties are broken round-robin, or by fixed HOST priority when configured.
- A runaway owner is forcibly released by a beat timeout.
- Sits between the control unit, host port and Datapath inside the Processor top.

Parameters:
- CMD_W, 28, width of the packed command bundle.
- HOST_PRIO, 0, 1 = HOST wins every tie/handoff; 0 = round-robin.
- MAX_BEATS, 16, maximum consecutive beats per grant before forced release (≥1).

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU requests the datapath
- cpu_last  in  1  current CPU beat ends its transaction
- cpu_cmd  in  CMD_W  CPU command bundle
- cpu_gnt  out  1  CPU owns the datapath this cycle
- host_req  in  1  HOST requests the datapath
- host_last  in  1  current HOST beat ends its transaction
- host_cmd  in  CMD_W  HOST command bundle
- host_gnt  out  1  HOST owns the datapath this cycle
- dp_mux_out  in  16  Datapath mux output (read return)
- dp_cmd  out  CMD_W  command bundle driven to the Datapath
- host_rdata  out  16  dp_mux_out captured at the end of HOST's last beat
- host_rvalid  out  1  one-cycle pulse: host_rdata updated
- err_timeout  out  1  sticky: a forced release has occurred
- arb_state  out  2  FSM state, for debug

Behaviour:
- Command bundle layout, LSB first: Alu_s[2:0], RF_Rb_rd, RF_Rb_addr[3:0], RF_Ra_rd, RF_Ra_addr[3:0], RF_W_wr, RF_W_addr[3:0], RF_s, D_wr, D_addr[7:0]; total 28 bits.
- Reset (Reset=0, asynchronous) clears:
  - state = IDLE; cpu_gnt = host_gnt = 0.
  - dp_cmd = 0: all enables low, all addresses 0.
  - host_rdata = 0, host_rvalid = 0, err_timeout = 0, beat counter = 0.
  - Round-robin pointer = HOST-last-served, so CPU wins the first tie.
  - A reset mid-transaction aborts it; no partial state is retained.
- States: IDLE=0, OWN_CPU=1, OWN_HOST=2. arb_state reflects the registered state.
- Grant outputs are registered: cpu_gnt = (state==OWN_CPU), host_gnt = (state==OWN_HOST).
- IDLE:
  - At the edge, one req → OWN_<that one>; both → winner per HOST_PRIO or the round-robin pointer; none → stay.
  - Latency: req first high in cycle N → gnt high in cycle N+1.
- Owned state, each cycle:
  - Owner req=1 → a beat: dp_cmd = owner cmd.
  - Owner req=0 → dp_cmd = 0 and ownership is abandoned at the edge (treated as last; no rdata capture).
- Release happens at the edge ending a beat with last=1, an abandon, or the MAX_BEATS-th beat without last.
- Next owner after release:
  - Other req high → other, with zero bubble: gnt moves in cycle M+1.
  - Else same req high → same requester keeps ownership.
  - Else → IDLE.
  - With HOST_PRIO=1, HOST is chosen whenever host_req is high.
- Round-robin pointer updates to the releasing owner on every release.
- Beat counter:
  - Counts beats within a grant; cleared on every grant start.
  - On reaching MAX_BEATS without last: forced release and err_timeout set.
  - err_timeout is cleared only by Reset.
  - The forced beat still drives dp_cmd normally.
- Read return:
  - At the edge ending a HOST beat with host_last=1 (normal release only), host_rdata ← dp_mux_out.
  - host_rvalid = 1 for exactly the following cycle.
  - A forced or abandoned HOST release produces no rvalid.
- Non-owner cmd inputs are ignored. dp_cmd is never a mix of both bundles.

Decomposition:
- Shared package dp_pkg holds:
  - CMD_W and the field offset/width constants for the bundle.
  - The arb_state encoding (IDLE/OWN_CPU/OWN_HOST).
  - The Alu_s opcode constants shared with the control unit.
- One natural sub-module, dp_arb_sel: combinational winner selection from (cpu_req, host_req, rr_ptr, HOST_PRIO).
- FSM, beat counter and read capture stay in dp_arbiter.

Test Plan:
- Reset mid-grant: HOST owning, pull Reset low → same instant gnts=0, dp_cmd=0, arb_state=0; after release, CPU wins a simultaneous req.
- Single CPU: cpu_req=1 at cycle 2, cpu_last=1 on the 3rd beat → cpu_gnt in cycles 3–5, dp_cmd=cpu_cmd in those cycles, IDLE at cycle 6 if req drops.
- Simultaneous requests, HOST_PRIO=0, both held with last=1 every beat → grants alternate CPU, HOST, CPU, … with no idle cycle between.
- HOST_PRIO=1, both continuously requesting → HOST granted every transaction; CPU granted only when host_req=0.
- HOST read: host_cmd D_addr=8'h2A, dp_mux_out=16'hBEEF on the last beat → host_rdata=16'hBEEF, host_rvalid high exactly one cycle after.
- Timeout: MAX_BEATS=4, CPU holds req with last=0 → exactly 4 beats, then cpu_gnt=0; err_timeout=1 and stays until Reset; a pending HOST is granted the next cycle.
